mul_div_unit_16: RTL and testbench
==================================

# mul_div_unit_16

Iterative 16-bit multiply/divide unit with HI/LO result registers for the single-cycle MIPS datapath. It consumes the two operands read from the 16-bit register file (rs to `a`, rt to `b`), runs one shift-add or restoring-divide step per clock, and holds results in HI/LO for later move-from reads. The controller stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 16, operand and HI/LO width; only 16 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin operation `op` on `a`,`b`; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  16  multiplicand or dividend (rs read data).
- `b`  in  16  multiplier or divisor (rt read data).
- `mt_hi`  in  1  write `a` to HI (MTHI); honoured only in IDLE.
- `mt_lo`  in  1  write `a` to LO (MTLO); honoured only in IDLE.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `div_by_zero`  out  1  sticky flag: last DIV/DIVU had `b`=0; cleared by next `start`.
- `hi`  out  16  HI register (product high half or remainder).
- `lo`  out  16  LO register (product low half or quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE with `start`=1:
  - latch `op`; latch magnitudes of `a`/`b` if signed op, else raw values;
  - latch result sign (MULT: sign a XOR sign b; DIV: quotient sign a XOR b, remainder sign = sign a);
  - clear counter and `div_by_zero`; go to RUN.
- RUN: exactly WIDTH (16) iterations, one per clock.
  - Multiply: 32-bit accumulate, LSB-first shift-add.
  - Divide: restoring; 17-bit partial remainder; one quotient bit per step, MSB first.
  - Counter reaches 15: go to FIX.
- FIX: apply two's-complement sign correction, write HI/LO, pulse `done`, go to IDLE.
- Divide by zero (`b`=0):
  - iterations still run full length;
  - FIX forces LO=16'hFFFF, HI=`a` as latched at start (original signed value);
  - `div_by_zero`=1.
- Signed overflow DIV 16'h8000 / 16'hFFFF: LO=16'h8000, HI=16'h0000, no flag.
- `start` while busy: ignored. No queueing and no restart.
- `mt_hi`/`mt_lo` while busy: ignored.
- `mt_hi`/`mt_lo` in IDLE with `start` in the same cycle: `start` wins and the move is dropped.
- `mt_hi` and `mt_lo` together: both written with `a`.
- Reset has priority over everything. The reset value of every output is 0: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset mid-operation aborts the operation. The partial result is discarded and no `done` is issued.

## Timing
- `start` sampled at edge E0: `busy`=1 from E0 to E17.
- HI/LO and `div_by_zero` update at E17. `done`=1 for the cycle between E17 and E18. `busy` is 0 in that same cycle.
- Latency from `start` edge to valid HI/LO is 17 clocks for every op, fixed and data-independent.
- A new `start` is accepted in the cycle `done` is high (back-to-back). That gives a throughput of one operation per 17 clocks.
- `mt_hi`/`mt_lo` update the register at the next edge, with 1-cycle latency.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MUL_DIV_SIGNED_EN` defined:
  - MULT/DIV perform signed magnitude conversion and FIX-state sign correction;
  - the signed overflow rule applies.
- Not defined:
  - `op[0]` is ignored, so MULT behaves as MULTU and DIV as DIVU;
  - the sign logic and the overflow rule are compiled out;
  - the divide-by-zero rule is unchanged, except HI = unsigned `a`.

## Structure
- Package `mul_div_pkg` holds:
  - `WIDTH`=16 and `ITER`=16;
  - the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, RUN, FIX).
- One sub-module, `sign_fix_16`: combinational conditional negate (abs on entry, negate on exit), instantiated for operand and result paths.

## Test plan
- MULTU `a`=16'h00FF, `b`=16'h0101 -> at E17 HI=16'h0000, LO=16'hFFFF; `done` pulses once; `busy` high for exactly 17 cycles.
- MULT `a`=16'hFFFD (-3), `b`=16'h0007 -> HI=16'hFFFF, LO=16'hFFEB. Without `MUL_DIV_SIGNED_EN` -> HI=16'h0006, LO=16'hFFEB.
- DIV `a`=16'hFFF9 (-7), `b`=16'h0002 -> LO=16'hFFFD, HI=16'hFFFF. DIVU `a`=1000, `b`=7 -> LO=142, HI=6.
- DIVU `a`=16'h0064, `b`=0 -> LO=16'hFFFF, HI=16'h0064, `div_by_zero`=1. A following MULTU clears the flag at its start.
- DIVU 1000/7 with a second `start` at E3 (ignored) and `reset` at E5 -> after E6 `busy`=0, HI=LO=0, no `done`.
- IDLE `mt_lo`=1, `a`=16'h1234 -> LO=16'h1234 next cycle. `mt_hi` with `start` in the same cycle -> HI is unchanged by the move; the operation starts.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared constants, op encoding and FSM states for the 16-bit multiply/divide unit.
package mul_div_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

endpackage

// File: rtl/sign_fix_16.sv
// Conditional two's-complement negate; cin lets two halves chain into a wider negate.
module sign_fix_16
    import mul_div_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    input  logic             cin,
    output logic [WIDTH-1:0] y
);

    assign y = (neg ? ~x : x) + {{(WIDTH-1){1'b0}}, neg & cin};

endmodule

// File: rtl/mul_div_unit_16.sv
// Iterative 16-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Signed ops are built only when MUL_DIV_SIGNED_EN is defined.
module mul_div_unit_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mul_div_pkg::*;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             finish;
    logic             mt_en;

    logic             is_div_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;

    logic             signed_op;
    logic             res_neg;
    logic             rem_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             hi_neg;
    logic             hi_cin;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic             unused_diff_msb;

`ifdef MUL_DIV_SIGNED_EN
    logic res_neg_q;
    logic rem_neg_q;

    assign signed_op = ~op[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (load) begin
            res_neg_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q <= signed_op & a[WIDTH-1];
        end
    end

    assign res_neg = res_neg_q;
    assign rem_neg = rem_neg_q;
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign signed_op  = 1'b0;
    assign res_neg    = 1'b0;
    assign rem_neg    = 1'b0;
`endif

    sign_fix_16 u_abs_a (
        .x   (a),
        .neg (signed_op & a[WIDTH-1]),
        .cin (1'b1),
        .y   (a_abs)
    );

    sign_fix_16 u_abs_b (
        .x   (b),
        .neg (signed_op & b[WIDTH-1]),
        .cin (1'b1),
        .y   (b_abs)
    );

    // Product high half only takes the +1 carry when the low half is zero.
    assign hi_neg = is_div_q ? rem_neg : res_neg;
    assign hi_cin = is_div_q | (acc_lo_q == '0);

    sign_fix_16 u_fix_lo (
        .x   (acc_lo_q),
        .neg (res_neg),
        .cin (1'b1),
        .y   (fix_lo)
    );

    sign_fix_16 u_fix_hi (
        .x   (acc_hi_q),
        .neg (hi_neg),
        .cin (hi_cin),
        .y   (fix_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == CNT_W'(ITER - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        mt_en  = 1'b0;
        unique case (state)
            IDLE: begin
                load  = start;
                mt_en = ~start;
            end
            RUN:     step   = 1'b1;
            FIX:     finish = 1'b1;
            default: ;
        endcase
    end

    assign mul_sum  = {1'b0, acc_hi_q}
                    + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = div_sh >= {1'b0, opnd_q};

    // Remainder stays below the divisor, so the top diff bit is always 0.
    assign unused_diff_msb = div_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (load) begin
            cnt      <= '0;
            is_div_q <= op[1];
            b_zero_q <= (b == '0);
            a_raw_q  <= a;
            opnd_q   <= b_abs;
            acc_hi_q <= '0;
            acc_lo_q <= a_abs;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_div_q) begin
                acc_hi_q <= div_ge ? div_diff[WIDTH-1:0]
                                   : div_sh[WIDTH-1:0];
                acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
                acc_hi_q <= mul_sum[WIDTH:1];
                acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                div_by_zero <= 1'b0;
            end
            if (finish) begin
                if (is_div_q && b_zero_q) begin
                    hi          <= a_raw_q;
                    lo          <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
            end else if (mt_en) begin
                if (mt_hi) hi <= a;
                if (mt_lo) lo <= a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= finish;
        end
    end

endmodule

// File: tb/tb_mul_div_unit_16.sv
// Directed + random bench for mul_div_unit_16 against an arithmetic reference.
module tb_mul_div_unit_16;

`ifdef MUL_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [15:0] hi;
    logic [15:0] lo;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_dz;

    always #5 clk = ~clk;

    mul_div_unit_16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mt_hi       (mt_hi),
        .mt_lo       (mt_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [15:0] x, y,
                                  output logic [15:0] eh, el,
                                  output logic ez);
        int     sx, sy, q, r;
        longint p;
        bit     sgn;
        sgn = SIGNED_EN && !o[0];
        ez  = 1'b0;
        if (!o[1]) begin
            if (sgn) begin
                sx = $signed(x);
                sy = $signed(y);
                p  = longint'(sx) * longint'(sy);
            end else begin
                p = longint'(x) * longint'(y);
            end
            {eh, el} = p[31:0];
        end else if (y == 16'h0000) begin
            el = 16'hFFFF;
            eh = x;
            ez = 1'b1;
        end else begin
            if (sgn) begin
                sx = $signed(x);
                sy = $signed(y);
            end else begin
                sx = int'(x);
                sy = int'(y);
            end
            q  = sx / sy;
            r  = sx % sy;
            el = q[15:0];
            eh = r[15:0];
        end
    endfunction

    // Call at a negedge; returns at the negedge right after the start edge.
    task automatic issue(input logic [1:0] o, input logic [15:0] x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        model(o, x, y, exp_hi, exp_lo, exp_dz);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks the busy window while poking moves/operand changes that must be ignored.
    task automatic wait_result(input string tag);
        int nb;
        nb = 0;
        chk($sformatf("%s_dz_clr", tag), div_by_zero, 0);
        while (busy && nb < 40) begin
            nb++;
            mt_hi = 1'($urandom_range(1));
            mt_lo = 1'($urandom_range(1));
            a     = 16'($urandom);
            @(negedge clk);
        end
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        chk($sformatf("%s_busy_cyc", tag), nb, 17);
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_hi", tag), hi, exp_hi);
        chk($sformatf("%s_lo", tag), lo, exp_lo);
        chk($sformatf("%s_dz", tag), div_by_zero, exp_dz);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk($sformatf("%s_done_once", tag), done, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        int dn;
        logic [1:0]  ro;
        logic [15:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;

        issue(2'b01, 16'h00FF, 16'h0101);
        wait_result("multu");
        chk("multu_hi_k", hi, 16'h0000);
        chk("multu_lo_k", lo, 16'hFFFF);
        idle_chk("multu");

        issue(2'b00, 16'hFFFD, 16'h0007);
        wait_result("mult");
        chk("mult_lo_k", lo, 16'hFFEB);
        chk("mult_hi_k", hi, SIGNED_EN ? 16'hFFFF : 16'h0006);
        idle_chk("mult");

        issue(2'b10, 16'hFFF9, 16'h0002);
        wait_result("div");
        idle_chk("div");

        issue(2'b11, 16'd1000, 16'd7);
        wait_result("divu");
        chk("divu_lo_k", lo, 16'd142);
        chk("divu_hi_k", hi, 16'd6);
        idle_chk("divu");

        issue(2'b11, 16'h0064, 16'h0000);
        wait_result("dz");
        chk("dz_flag_k", div_by_zero, 1);
        issue(2'b01, 16'h0003, 16'h0005);
        wait_result("b2b_multu");
        idle_chk("b2b");

        issue(2'b10, 16'h8000, 16'hFFFF);
        wait_result("ovf");
        idle_chk("ovf");

        mt_lo = 1'b1;
        a     = 16'h1234;
        @(negedge clk);
        mt_lo = 1'b0;
        chk("mtlo", lo, 16'h1234);
        mt_hi = 1'b1;
        a     = 16'h5678;
        @(negedge clk);
        mt_hi = 1'b0;
        chk("mthi", hi, 16'h5678);
        chk("mthi_lo_kept", lo, 16'h1234);
        mt_hi = 1'b1;
        mt_lo = 1'b1;
        a     = 16'hABCD;
        @(negedge clk);
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        chk("mtboth_hi", hi, 16'hABCD);
        chk("mtboth_lo", lo, 16'hABCD);

        mt_hi = 1'b1;
        issue(2'b01, 16'h0003, 16'h0005);
        mt_hi = 1'b0;
        chk("mt_vs_start_hi", hi, 16'hABCD);
        chk("mt_vs_start_busy", busy, 1);
        wait_result("mt_start");
        idle_chk("mt_start");

        issue(2'b11, 16'd1000, 16'd7);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 16'h0003;
        b     = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_mid", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_idle", busy, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(7))
                0: rb = 16'h0000;
                1: begin ra = 16'h8000; rb = 16'hFFFF; end
                2: rb = 16'hFFFF;
                default: ;
            endcase
            issue(ro, ra, rb);
            wait_result($sformatf("rnd%0d_op%0d", i, ro));
            if ($urandom_range(1) == 1) idle_chk("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
